decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning select width; out width is 2**N; legal range 1..6.
REQ-002 The block SHALL have parameter DWELL_W, default 4, meaning dwell-count width in scan mode.
REQ-003 The block SHALL have port clk, input, 1, meaning single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1, meaning output enable; low forces out to zero and freezes scan state.
REQ-006 The block SHALL have port mode, input, 1, meaning 0 = direct decode, 1 = auto-scan.
REQ-007 The block SHALL have port sel, input, N, meaning select index used in direct mode.
REQ-008 The block SHALL have port dwell, input, DWELL_W, meaning extra cycles each index is held in scan mode.
REQ-009 The block SHALL have port out, output, 2**N, meaning registered one-hot decode of idx, or all zeros.
REQ-010 The block SHALL have port idx, output, N, meaning current registered index.
REQ-011 The block SHALL have port wrap, output, 1, meaning one-cycle pulse when the scan index wraps from 2**N-1 to 0.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 In direct mode with en=1, the block SHALL load idx<=sel and out<=1<<sel, so out reflects sel one cycle after sampling.
REQ-014 In direct mode, the dwell counter SHALL be held at 0 and wrap SHALL be 0.
REQ-015 In scan mode with en=1, the dwell counter SHALL increment each cycle until it is >= dwell, then clear to 0 while idx increments modulo 2**N.
REQ-016 Each index SHALL therefore be held for dwell+1 cycles, and dwell=0 SHALL advance idx every cycle.
REQ-017 The comparison SHALL be >= so that lowering dwell below the current count forces an advance on the next edge.
REQ-018 In scan mode, out SHALL equal 1<<idx in the same cycle idx is presented, so the two always agree.
REQ-019 The wrap output SHALL be asserted for exactly the one cycle in which idx becomes 0 from 2**N-1 by scan advance; a direct-mode load of 0 SHALL NOT assert wrap.
REQ-020 When en=0, the block SHALL set out<=0 and wrap<=0, and SHALL hold idx and the dwell counter in both modes.
REQ-021 When en returns high in scan mode, the block SHALL resume from the frozen idx and dwell count, with out<=1<<idx on the first enabled edge.
REQ-022 On a direct-to-scan switch, scanning SHALL start from the current idx with the dwell counter cleared to 0.
REQ-023 On a scan-to-direct switch, idx SHALL load sel on the same edge and the dwell counter SHALL clear.
REQ-024 Arithmetic SHALL be unsigned; the idx increment SHALL wrap naturally at N bits, and the dwell counter SHALL NOT overflow because it clears at >= dwell.

Reset
REQ-025 On a clk edge with rst=1, the block SHALL set out=0, idx=0, wrap=0 and dwell counter=0, overriding en, mode and sel.
REQ-026 Reset asserted mid-scan or mid-dwell SHALL abandon the current count, and scanning SHALL restart at idx=0 with a full dwell period on the first edge after rst deasserts.
REQ-027 Until the first enabled edge after reset, out SHALL remain 0 even if mode=1.

Verification (N=2, DWELL_W=4)
REQ-028 Direct sweep: drive rst then en=0 with sel 0..3 -> out=0000 throughout; then en=1 with sel 0,1,2,3 -> out=0001,0010,0100,1000, each one cycle after sel.
REQ-029 Scan with dwell=0 and en=1 from reset -> out cycles 0001,0010,0100,1000,0001 on consecutive cycles, with wrap high only in the cycle out returns to 0001.
REQ-030 Scan with dwell=2 -> each one-hot value is held for 3 cycles, a full wrap takes 12 cycles, and wrap pulses once per 12 cycles.
REQ-031 Freeze: in scan with dwell=2 at idx=2 after 1 dwell cycle, drop en for 5 cycles -> out=0000 and idx=2 held; on raising en -> out=0100 for 2 more cycles, then 1000.
REQ-032 Dwell shrink: at dwell count 3 with dwell=5, change dwell to 1 -> idx advances on the next edge.
REQ-033 Reset and mode switch: assert rst mid-scan at idx=3 -> next cycle out=0000 and idx=0; then mode=0 with sel=2 -> out=0100 and no wrap pulse.

Source files
------------

// File: rtl/decoder_scan_if.sv
// Control and decode bus for decoder_scan: the control inputs are driven by the master,
// and the registered decode results are driven back by the slave.
interface decoder_scan_if #(
    parameter int N       = 2,
    parameter int DWELL_W = 4
);
    logic                 en;
    logic                 mode;
    logic [N-1:0]         sel;
    logic [DWELL_W-1:0]   dwell;
    logic [(1<<N)-1:0]    out;
    logic [N-1:0]         idx;
    logic                 wrap;

    modport master (
        output en, mode, sel, dwell,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, sel, dwell,
        output out, idx, wrap
    );
endinterface

// File: rtl/decoder_scan.sv
// Purpose: one-hot decoder with direct-select and auto-scan (dwell-timed) modes.
// Latency: every output is registered, one cycle after the inputs are sampled.
// Backpressure: none; en=0 blanks out and freezes the scan position.
module decoder_scan #(
    parameter int N       = 2,
    parameter int DWELL_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    decoder_scan_if.slave  bus
);
    localparam int W = 1 << N;

    typedef enum logic {
        ST_FRESH,
        ST_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]         out_q, out_d;
    logic                 wrap_q, wrap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FRESH;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    // ST_FRESH: nothing has been shown since reset, so the first enabled scan
    // edge presents idx 0 without consuming any of its dwell period.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        out_d   = '0;
        wrap_d  = 1'b0;
        if (bus.en) begin
            if (!bus.mode) begin
                idx_d   = bus.sel;
                cnt_d   = '0;
                state_d = ST_RUN;
            end else if (state_q == ST_FRESH) begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end else if (cnt_q >= bus.dwell) begin
                idx_d   = idx_q + N'(1);
                cnt_d   = '0;
                wrap_d  = (idx_q == {N{1'b1}});
            end else begin
                cnt_d   = cnt_q + DWELL_W'(1);
            end
            out_d[idx_d] = 1'b1;
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Directed and randomized checks of decoder_scan against a reference model of the decode/scan rules.
module tb_decoder_scan;
    localparam int N  = 2;
    localparam int DW = 4;
    localparam int W  = 1 << N;

    logic clk = 1'b0;
    logic rst;

    decoder_scan_if #(.N(N), .DWELL_W(DW)) bus ();

    decoder_scan #(.N(N), .DWELL_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: position, cycles already spent at it, and whether
    // anything has been shown since reset.
    int m_idx;
    int m_cnt;
    bit m_fresh;
    int m_out;
    int m_wrap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_idx = 0; m_cnt = 0; m_out = 0; m_wrap = 0; m_fresh = 1;
        end else if (!bus.en) begin
            m_out = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (!bus.mode) begin
                m_idx = int'(bus.sel); m_cnt = 0; m_fresh = 0;
            end else if (m_fresh) begin
                m_fresh = 0; m_cnt = 0;
            end else if (m_cnt >= int'(bus.dwell)) begin
                m_idx  = (m_idx + 1) % W;
                m_cnt  = 0;
                m_wrap = (m_idx == 0) ? 1 : 0;
            end else begin
                m_cnt++;
            end
            m_out = 1 << m_idx;
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, "/out"},  32'(bus.out),  32'(m_out));
        check({tag, "/idx"},  32'(bus.idx),  32'(m_idx));
        check({tag, "/wrap"}, 32'(bus.wrap), 32'(m_wrap));
    endtask

    initial begin
        int wraps;
        int exp_out29 [5];
        int exp_wrap29 [5];
        exp_out29  = '{1, 2, 4, 8, 1};
        exp_wrap29 = '{0, 0, 0, 0, 1};

        rst = 1'b1; bus.en = 1'b0; bus.mode = 1'b0; bus.sel = '0; bus.dwell = '0;
        m_idx = 0; m_cnt = 0; m_out = 0; m_wrap = 0; m_fresh = 1;
        tick("reset0");
        tick("reset1");
        check("reset_out_const", 32'(bus.out), 32'd0);

        // Direct sweep: disabled, then enabled
        rst = 1'b0;
        for (int i = 0; i < W; i++) begin
            bus.sel = N'(i);
            tick("dir_off");
            check("dir_off_const", 32'(bus.out), 32'd0);
        end
        bus.en = 1'b1;
        for (int i = 0; i < W; i++) begin
            bus.sel = N'(i);
            tick("dir_on");
            check("dir_on_const", 32'(bus.out), 32'(1 << i));
        end

        // Scan with dwell=0 from reset
        rst = 1'b1; tick("rst29");
        rst = 1'b0; bus.mode = 1'b1; bus.dwell = '0;
        for (int i = 0; i < 5; i++) begin
            tick("scan0");
            check("scan0_out_const",  32'(bus.out),  32'(exp_out29[i]));
            check("scan0_wrap_const", 32'(bus.wrap), 32'(exp_wrap29[i]));
        end

        // Scan with dwell=2: 3 cycles per index, wrap every 12
        rst = 1'b1; tick("rst30");
        rst = 1'b0; bus.dwell = DW'(2);
        wraps = 0;
        for (int i = 0; i < 25; i++) begin
            tick("scan2");
            check("scan2_hold_const", 32'(bus.out), 32'(1 << ((i / 3) % W)));
            if (bus.wrap) wraps++;
        end
        check("scan2_wrap_count", 32'(wraps), 32'd2);

        // Freeze at idx 2 after its first presented cycle
        for (int i = 0; i < 6; i++) tick("to_idx2");
        check("freeze_pre_idx", 32'(bus.idx), 32'd2);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick("frozen");
            check("frozen_out_const", 32'(bus.out), 32'd0);
            check("frozen_idx_const", 32'(bus.idx), 32'd2);
        end
        bus.en = 1'b1;
        tick("resume1"); check("resume1_const", 32'(bus.out), 32'h4);
        tick("resume2"); check("resume2_const", 32'(bus.out), 32'h4);
        tick("resume3"); check("resume3_const", 32'(bus.out), 32'h8);

        // Dwell shrink at count 3
        bus.dwell = DW'(5);
        for (int i = 0; i < 3; i++) tick("dwell5");
        check("shrink_pre_const", 32'(bus.out), 32'h8);
        bus.dwell = DW'(1);
        tick("shrink");
        check("shrink_out_const",  32'(bus.out),  32'h1);
        check("shrink_wrap_const", 32'(bus.wrap), 32'd1);

        // Reset mid-scan at idx 3, then direct load of 2
        bus.dwell = '0;
        for (int i = 0; i < 3; i++) tick("to_idx3");
        check("pre_rst_idx", 32'(bus.idx), 32'd3);
        rst = 1'b1; tick("rst33");
        check("rst33_out_const", 32'(bus.out), 32'd0);
        check("rst33_idx_const", 32'(bus.idx), 32'd0);
        rst = 1'b0; bus.mode = 1'b0; bus.sel = N'(2);
        tick("dir_after_rst");
        check("dir2_out_const",  32'(bus.out),  32'h4);
        check("dir2_wrap_const", 32'(bus.wrap), 32'd0);

        // Randomized mixture of modes, enables, dwell changes and resets
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            bus.en    = ($urandom_range(0, 4) != 0);
            bus.mode  = ($urandom_range(0, 3) != 0);
            bus.sel   = N'($urandom_range(0, W - 1));
            bus.dwell = DW'($urandom_range(0, 3));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
